dmem_arbiter: RTL and testbench

//  Shares the single-port DataMemory between two requesters: the pipeline MEM stage (core) and a
//  DMA/loader port that fills or dumps memory while the CPU runs. Sequences each access over a

---
 rtl/dmem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the pipeline MEM stage (core)
// and a DMA/loader port.
//   Each grant drives mem_* for a fixed MEM_LAT-cycle window, then pulses the owner's ack
//   for one cycle with read data valid.
//   The core wins ties unless the DMA has already lost STARVE_MAX times in a row.
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   core_req/we/addr/wdata   core request (held until core_ack)
//   core_rdata/ack/stall     core read data, one-cycle ack, stall = req & ~ack
//   dma_req/we/addr/wdata    DMA request (held until dma_ack)
//   dma_rdata/ack            DMA read data, one-cycle ack
//   mem_en/we/addr/wdata     memory strobe, write enable, address and write data
//   mem_rdata                memory read data, sampled on the last window cycle
//   perf_conflict            IDLE cycles with both requests high (saturating)
//   perf_dma_grants          DMA grant count (saturating)
//   The two perf_* ports exist only when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic [DW-1:0] core_rdata,
   output logic          core_ack,
   output logic          core_stall,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_ack,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [15:0]   perf_conflict,
   output logic [15:0]   perf_dma_grants
`endif
);
   localparam int SW = $clog2(STARVE_MAX + 1);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic {CORE, DMA} owner_t;
   generate
      if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_lat_chk
         $error("dmem_arbiter: MEM_LAT must be in 1..4");
      end
   endgenerate
   state_t        state_q, state_d;
   owner_t        owner_q, owner_d;
   logic [SW-1:0] starve_cnt_q, starve_cnt_d;
   logic [1:0]    lat_cnt_q, lat_cnt_d;
   logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] core_rdata_q, core_rdata_d, dma_rdata_q, dma_rdata_d;
   logic          dma_win, starved, last_lat;
   always_comb begin
      starved      = starve_cnt_q == SW'(STARVE_MAX);
      dma_win      = dma_req & (~core_req | starved);
      last_lat     = lat_cnt_q == 2'(MEM_LAT - 1);
      state_d      = state_q;
      owner_d      = owner_q;
      starve_cnt_d = starve_cnt_q;
      lat_cnt_d    = lat_cnt_q;
      mem_en_d     = mem_en_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      core_rdata_d = core_rdata_q;
      dma_rdata_d  = dma_rdata_q;
      case (state_q)
         IDLE: begin
            if (core_req | dma_req) begin
               state_d     = ACCESS;
               owner_d     = dma_win ? DMA : CORE;
               mem_en_d    = 1'b1;
               mem_we_d    = dma_win ? dma_we : core_we;
               mem_addr_d  = dma_win ? dma_addr : core_addr;
               mem_wdata_d = dma_win ? dma_wdata : core_wdata;
               lat_cnt_d   = 2'd0;
               // Counts consecutive core wins over a waiting DMA; any DMA grant or an
               // uncontested core grant restarts the count.
               starve_cnt_d = (dma_win | ~dma_req) ? '0 :
                              starved ? starve_cnt_q : starve_cnt_q + 1'b1;
            end
         end
         ACCESS: begin
            lat_cnt_d = lat_cnt_q + 1'b1;
            if (last_lat) begin
               state_d  = DONE;
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               core_rdata_d = (!mem_we_q && owner_q == CORE) ? mem_rdata : core_rdata_q;
               dma_rdata_d  = (!mem_we_q && owner_q == DMA) ? mem_rdata : dma_rdata_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         owner_q      <= CORE;
         starve_cnt_q <= '0;
         lat_cnt_q    <= 2'd0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         core_rdata_q <= '0;
         dma_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         starve_cnt_q <= starve_cnt_d;
         lat_cnt_q    <= lat_cnt_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         core_rdata_q <= core_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
      end
   end
   assign core_ack   = state_q == DONE && owner_q == CORE;
   assign dma_ack    = state_q == DONE && owner_q == DMA;
   assign core_stall = core_req & ~core_ack;
   assign core_rdata = core_rdata_q;
   assign dma_rdata  = dma_rdata_q;
   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
`ifdef DMEM_ARB_PERF_EN
   logic [15:0] perf_conflict_q, perf_conflict_d, perf_dma_grants_q, perf_dma_grants_d;
   always_comb begin
      perf_conflict_d   = perf_conflict_q;
      perf_dma_grants_d = perf_dma_grants_q;
      if (state_q == IDLE && core_req && dma_req && perf_conflict_q != 16'hFFFF)
         perf_conflict_d = perf_conflict_q + 16'd1;
      if (state_q == IDLE && dma_win && perf_dma_grants_q != 16'hFFFF)
         perf_dma_grants_d = perf_dma_grants_q + 16'd1;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_conflict_q   <= 16'd0;
         perf_dma_grants_q <= 16'd0;
      end else begin
         perf_conflict_q   <= perf_conflict_d;
         perf_dma_grants_q <= perf_dma_grants_d;
      end
   end
   assign perf_conflict   = perf_conflict_q;
   assign perf_dma_grants = perf_dma_grants_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized scoreboard bench for dmem_arbiter (MEM_LAT=3, STARVE_MAX=4).
//   A transaction-level model decides grants from the arbitration rules, keeps its own copy
//   of memory, and queues the expected ack cycle and read data per port; a negedge monitor
//   pops and compares. Perf counters are checked when DMEM_ARB_PERF_EN is defined.
module tb_dmem_arbiter;
   localparam int LAT  = 3;
   localparam int SMAX = 4;
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack_cyc;
   } xact_t;
   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        core_req = 1'b0, core_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
   logic [31:0] core_addr = '0, core_wdata = '0, dma_addr = '0, dma_wdata = '0;
   logic [31:0] core_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        core_ack, dma_ack, core_stall, mem_en, mem_we;
`ifdef DMEM_ARB_PERF_EN
   logic [15:0] perf_conflict, perf_dma_grants;
`endif
   int          checks = 0, failures = 0;
   always #5 clk = ~clk;
   dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .reset_n(reset_n),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_rdata(core_rdata), .core_ack(core_ack), .core_stall(core_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
      , .perf_conflict(perf_conflict), .perf_dma_grants(perf_dma_grants)
`endif
   );
   function automatic logic [31:0] seed(int i);
      return 32'hC0DE_0000 + 32'(i) * 32'h0101_0111;
   endfunction
   // Memory behind the arbiter: combinational read, write on every enabled edge.
   logic [31:0] ram [16];
   logic        ram_seeded = 1'b0;
   assign mem_rdata = ram[mem_addr[5:2]];
   always @(posedge clk) begin
      if (!ram_seeded) begin
         for (int i = 0; i < 16; i++) ram[i] <= seed(i);
         ram_seeded <= 1'b1;
      end else if (mem_en && mem_we) ram[mem_addr[5:2]] <= mem_wdata;
   end
   // Reference model: grants happen on IDLE-cycle edges; a grant occupies LAT+2 cycles.
   xact_t       cq[$], dq[$], t;
   logic [31:0] mm [16];
   logic [31:0] core_last = '0, dma_last = '0, win_addr = '0, win_wdata = '0;
   logic        win_we = 1'b0, m_init = 1'b0, d;
   int          cyc = 0, free_cyc = 0, win_lo = -1, win_hi = -2, sc = 0, m_conf = 0, m_dg = 0;
   always @(posedge clk) begin
      if (!m_init) begin
         for (int i = 0; i < 16; i++) mm[i] = seed(i);
         m_init = 1'b1;
      end
      if (!reset_n) begin
         cq.delete();
         dq.delete();
         sc = 0; free_cyc = 0; win_lo = -1; win_hi = -2; m_conf = 0; m_dg = 0;
         core_last = '0; dma_last = '0;
      end else if (cyc >= free_cyc) begin
         if (core_req && dma_req && m_conf < 65535) m_conf++;
         if (core_req || dma_req) begin
            d = dma_req && (!core_req || sc == SMAX);
            t.we      = d ? dma_we : core_we;
            t.addr    = d ? dma_addr : core_addr;
            t.wdata   = d ? dma_wdata : core_wdata;
            t.ack_cyc = cyc + LAT + 1;
            if (t.we) begin
               mm[t.addr[5:2]] = t.wdata;
               t.rdata = d ? dma_last : core_last;
            end else begin
               t.rdata = mm[t.addr[5:2]];
               if (d) dma_last = t.rdata; else core_last = t.rdata;
            end
            if (d) begin
               dq.push_back(t);
               sc = 0;
               if (m_dg < 65535) m_dg++;
            end else begin
               cq.push_back(t);
               sc = dma_req ? (sc < SMAX ? sc + 1 : sc) : 0;
            end
            win_lo = cyc + 1; win_hi = cyc + LAT;
            win_we = t.we; win_addr = t.addr; win_wdata = t.wdata;
            free_cyc = cyc + LAT + 2;
         end
      end
      cyc++;
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask
   // Monitor
   logic  rec = 1'b0, ord_timeout = 1'b0, ord_checked = 1'b0, ec, ed, en;
   string ord = "", exp_ord = "CCCCDCCCCD";
   always @(negedge clk) begin
      if (!reset_n) begin
         chk("rst_mem_en", mem_en, 0);
         chk("rst_mem_we", mem_we, 0);
         chk("rst_core_ack", core_ack, 0);
         chk("rst_dma_ack", dma_ack, 0);
         chk("rst_mem_addr", mem_addr, 0);
         chk("rst_mem_wdata", mem_wdata, 0);
         chk("rst_core_rdata", core_rdata, 0);
         chk("rst_dma_rdata", dma_rdata, 0);
         chk("rst_core_stall", core_stall, core_req);
      end else begin
         ec = cq.size() > 0 && cq[0].ack_cyc == cyc;
         ed = dq.size() > 0 && dq[0].ack_cyc == cyc;
         chk("core_ack", core_ack, ec);
         chk("dma_ack", dma_ack, ed);
         chk("core_stall", core_stall, core_req && !ec);
         if (ec) begin
            chk("core_rdata", core_rdata, cq[0].rdata);
            void'(cq.pop_front());
         end
         if (ed) begin
            chk("dma_rdata", dma_rdata, dq[0].rdata);
            void'(dq.pop_front());
         end
         if (rec && core_ack) ord = {ord, "C"};
         if (rec && dma_ack) ord = {ord, "D"};
         en = cyc >= win_lo && cyc <= win_hi;
         chk("mem_en", mem_en, en);
         if (en) begin
            chk("mem_we", mem_we, win_we);
            chk("mem_addr", mem_addr, win_addr);
            chk("mem_wdata", mem_wdata, win_wdata);
         end else chk("mem_we_idle", mem_we, 0);
`ifdef DMEM_ARB_PERF_EN
         chk("perf_conflict", perf_conflict, m_conf);
         chk("perf_dma_grants", perf_dma_grants, m_dg);
`endif
      end
      if (!ord_checked && ord.len() >= 10) begin
         ord_checked = 1'b1;
         for (int i = 0; i < 10; i++) chk($sformatf("grant_order[%0d]", i), ord[i], exp_ord[i]);
      end else if (!ord_checked && ord_timeout) begin
         ord_checked = 1'b1;
         chk("grant_order_timeout", ord.len(), 10);
      end
   end
   // Stimulus
   task automatic new_core(input logic hold);
      core_req   = hold || $urandom_range(0, 3) != 0;
      core_we    = 1'($urandom);
      core_addr  = {26'd0, 4'($urandom), 2'b00};
      core_wdata = $urandom;
   endtask
   task automatic new_dma(input logic hold);
      dma_req   = hold || $urandom_range(0, 3) != 0;
      dma_we    = 1'($urandom);
      dma_addr  = {26'd0, 4'($urandom), 2'b00};
      dma_wdata = $urandom;
   endtask
   // Pending requesters occasionally wiggle their payload: before the grant it is simply
   // the request that gets served, after the grant the arbiter must ignore it.
   task automatic rnd_step();
      if (!core_req || core_ack) new_core(1'b0);
      else if ($urandom_range(0, 7) == 0) new_core(1'b1);
      if (!dma_req || dma_ack) new_dma(1'b0);
      else if ($urandom_range(0, 7) == 0) new_dma(1'b1);
   endtask
   task automatic quiesce();
      for (int i = 0; i < 200 && (core_req || dma_req); i++) begin
         @(posedge clk);
         #1;
         if (core_ack) core_req = 1'b0;
         if (dma_ack) dma_req = 1'b0;
      end
      core_req = 1'b0;
      dma_req  = 1'b0;
      repeat (LAT + 3) @(posedge clk);
      #1;
   endtask
   initial begin
      int n;
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      rec = 1'b1;
      new_core(1'b1);
      new_dma(1'b1);
      n = 0;
      for (int i = 0; i < 200 && n < 10; i++) begin
         @(posedge clk);
         #1;
         n += int'(core_ack) + int'(dma_ack);
         if (core_ack) new_core(1'b1);
         if (dma_ack) new_dma(1'b1);
      end
      core_req = 1'b0;
      dma_req  = 1'b0;
      if (n < 10) ord_timeout = 1'b1;
      repeat (3) @(posedge clk);
      #1 rec = 1'b0;
      repeat (3000) begin
         @(posedge clk);
         #1 rnd_step();
      end
      quiesce();
      core_we   = 1'b0;
      core_addr = 32'h10;
      core_req  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset_n  = 1'b0;
      core_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      repeat (500) begin
         @(posedge clk);
         #1 rnd_step();
      end
      quiesce();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
